regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (we3/wa3/wd3) between NREQ writeback requesters, for example ALU writeback and load writeback.
- Each requester gets a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains the buffers into a registered write port that connects directly to the register file.
- Also exports a pending-write mask so the hazard/stall logic can see registers with writes in flight.

Parameters:
- NREQ, 2, number of writeback requesters (2..4).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request valid.
- req_ready  out  NREQ  per-requester accept; a transfer occurs when valid && ready at a rising edge.
- req_addr  in  NREQ*AW  flattened destination addresses; requester i occupies bits [i*AW +: AW].
- req_data  in  NREQ*DW  flattened write data; requester i occupies bits [i*DW +: DW].
- we3  out  1  register file write enable (registered).
- wa3  out  AW  register file write address (registered).
- wd3  out  DW  register file write data (registered).
- pending_mask  out  2**AW  bit r set if a write to register r is buffered or currently presented on the port.
- idle  out  1  high when no buffer is valid and we3 is low.

Behaviour:
Clocking and reset
- Single clock, clk; reset is synchronous and active-high.
- Reset values: buf_valid = 0 for every requester, we3 = 0, wa3 = 0, wd3 = 0, round-robin pointer = 0.
- Derived outputs after reset: req_ready all 1, pending_mask = 0, idle = 1.
- Reset asserted mid-operation discards all buffered writes; we3 is 0 in the cycle after the reset edge.

Holding buffers
- Each requester i has buf_valid[i], buf_addr[i] and buf_data[i].
- req_ready[i] = !buf_valid[i] || grant[i]. Combinational; it never depends on req_valid.
- Acceptance of an address equal to 0: the request is consumed (ready honoured) but not buffered. buf_valid is unchanged, unless a grant empties it.
- Acceptance of a nonzero address: the buffer loads addr/data and buf_valid is set.
- Simultaneous grant and new acceptance on the same requester: the buffer reloads and stays valid. This gives full throughput of one write per cycle per requester when uncontended.

Arbitration
- Purely combinational over buf_valid.
- Search starts at the pointer index and wraps modulo NREQ; the first valid buffer is granted. At most one grant per cycle.
- On a grant to index g: at the edge, we3 <= 1, wa3 <= buf_addr[g], wd3 <= buf_data[g], buf_valid[g] clears (unless reloaded), and pointer <= (g+1) mod NREQ.
- With no grant: we3 <= 0, wa3/wd3 hold their values, pointer holds.

Latency
- A request accepted at edge E0 is eligible for grant in the following cycle.
- If granted at edge E1, we3 is high in the cycle after E1 and the register file captures the write at E2.
- Minimum accept-to-register-file-write latency is therefore 2 edges.

Ordering
- Writes from one requester leave in acceptance order.
- Two requesters targeting the same address are resolved in grant order; the last write wins. There is no merging.

Fairness
- With all NREQ buffers continuously valid, each requester is granted exactly once every NREQ cycles.

pending_mask and idle
- pending_mask is the OR of one-hot(buf_addr[i]) for each valid buffer, plus one-hot(wa3) when we3 = 1.
- Bit 0 of pending_mask is always 0.
- idle = !(|buf_valid) && !we3.

Decomposition:
- Shared package: AW = 5, DW = 32, default NREQ, and a constant REG_ZERO = 0.
- Sub-module rr_arbiter (parameter NREQ):
  - inputs: clk, reset, req vector, advance.
  - outputs: one-hot grant.
  - owns the pointer register.
- The top level owns the buffers, the output registers and the pending_mask logic.

Test Plan:
1. Reset then idle: after reset, req_ready = 2'b11, we3 = 0, wa3 = 0, wd3 = 0, pending_mask = 0, idle = 1.
2. Single write: req0 addr = 5, data = 0xDEADBEEF for one cycle. Response: pending_mask[5] = 1 for 2 cycles; we3 = 1, wa3 = 5, wd3 = 0xDEADBEEF exactly one cycle, two edges after acceptance; then idle = 1.
3. Contention: both requesters valid every cycle (req0 addr = 3, req1 addr = 7, incrementing data) for 8 cycles. Response: wa3 alternates 3,7,3,7...; each requester's ready is high every other cycle; no data is lost or duplicated.
4. r0 discard: req1 addr = 0, data = 0x1234. Response: accepted (ready = 1), we3 stays 0, pending_mask stays 0, idle stays 1.
5. Same-address collision: req0 and req1 both addr = 9 in the same cycle, data 0xA and 0xB, pointer = 0. Response: wd3 = 0xA then 0xB on consecutive cycles; final register value is 0xB.
6. Reset mid-operation: both buffers full, reset asserted one cycle. Response: the next cycle has we3 = 0, pending_mask = 0, req_ready = 2'b11, and neither buffered write appears on the port.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants for the register-file writeback arbiter
package regfile_wb_arbiter_pkg;

    localparam int AW_DEFAULT   = 5;
    localparam int DW_DEFAULT   = 32;
    localparam int NREQ_DEFAULT = 2;
    // Writes to r0 are architecturally dropped, so they never occupy a buffer.
    localparam int REG_ZERO     = 0;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// rtl/regfile_wb_arbiter_rr.sv - round-robin grant over request vector, owns the pointer
module rr_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;
    int            idx;

    // Scan from the pointer, wrapping modulo NREQ; first valid requester wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= PW'((int'(gidx) + 1) % NREQ);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port among NREQ writeback sources
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int AW   = AW_DEFAULT,
    parameter int DW   = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 we3,
    output logic [AW-1:0]        wa3,
    output logic [DW-1:0]        wd3,
    output logic [(2**AW)-1:0]   pending_mask,
    output logic                 idle
);

    logic [NREQ-1:0] buf_valid;
    logic [AW-1:0]   buf_addr [NREQ];
    logic [DW-1:0]   buf_data [NREQ];
    logic [NREQ-1:0] grant;
    logic            advance;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [(2**AW)-1:0] pm;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (buf_valid),
        .advance (advance),
        .grant   (grant)
    );

    assign advance   = |grant;
    // A buffer being drained this cycle can take a new entry at the same edge.
    assign req_ready = ~buf_valid | grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = buf_addr[i];
                sel_data = buf_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    buf_valid[i] <= 1'b0;
                end
                if (req_valid[i] && req_ready[i] &&
                    req_addr[i*AW +: AW] != AW'(REG_ZERO)) begin
                    buf_valid[i] <= 1'b1;
                    buf_addr[i]  <= req_addr[i*AW +: AW];
                    buf_data[i]  <= req_data[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            we3 <= advance;
            if (advance) begin
                wa3 <= sel_addr;
                wd3 <= sel_data;
            end
        end
    end

    always_comb begin
        pm = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (buf_valid[i]) begin
                pm[buf_addr[i]] = 1'b1;
            end
        end
        if (we3) begin
            pm[wa3] = 1'b1;
        end
        pm[REG_ZERO] = 1'b0;
    end

    assign pending_mask = pm;
    assign idle         = !(|buf_valid) && !we3;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] pending_mask;
    logic        idle;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(.NREQ(2), .AW(5), .DW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .we3          (we3),
        .wa3          (wa3),
        .wd3          (wd3),
        .pending_mask (pending_mask),
        .idle         (idle)
    );

    always #5 clk = ~clk;

    // Reference model: one-entry buffers, a round-robin start index and the write port.
    int          m_ptr;
    bit          m_v [2];
    logic [4:0]  m_a [2];
    logic [31:0] m_d [2];
    bit          m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [31:0] rf [32];

    function automatic int m_grant();
        for (int k = 0; k < 2; k++) begin
            if (m_v[(m_ptr + k) % 2]) return (m_ptr + k) % 2;
        end
        return -1;
    endfunction

    function automatic logic [1:0] m_ready();
        logic [1:0] r;
        int g;
        g = m_grant();
        for (int i = 0; i < 2; i++) r[i] = !m_v[i] || (g == i);
        return r;
    endfunction

    function automatic logic [31:0] exp_pm();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 2; i++) if (m_v[i]) p[m_a[i]] = 1'b1;
        if (m_we) p[m_wa] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    function automatic logic exp_idle();
        return !m_v[0] && !m_v[1] && !m_we;
    endfunction

    task automatic model_edge();
        int g;
        logic [1:0] rdy;
        g   = m_grant();
        rdy = m_ready();
        if (reset) begin
            m_v[0] = 0; m_v[1] = 0; m_ptr = 0;
            m_we = 0; m_wa = '0; m_wd = '0;
            return;
        end
        if (g >= 0) begin
            m_we = 1; m_wa = m_a[g]; m_wd = m_d[g];
            m_v[g] = 0; m_ptr = (g + 1) % 2;
        end else begin
            m_we = 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && rdy[i] && req_addr[i*5 +: 5] != 5'd0) begin
                m_v[i] = 1; m_a[i] = req_addr[i*5 +: 5]; m_d[i] = req_data[i*32 +: 32];
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        if (we3 === 1'b1) rf[wa3] = wd3;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]       = v;
        req_addr[i*5 +: 5] = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        tick(); tick();
        reset = 1'b0;
        n_checks++; if (req_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready got %b want 11", req_ready); end
        n_checks++; if (we3 !== 1'b0) begin n_fail++; $display("FAIL reset_we3 got %b want 0", we3); end
        n_checks++; if (wa3 !== 5'd0 || wd3 !== 32'd0) begin n_fail++; $display("FAIL reset_wa3_wd3 got %0d/%h want 0/0", wa3, wd3); end
        n_checks++; if (pending_mask !== 32'd0) begin n_fail++; $display("FAIL reset_pending got %h want 0", pending_mask); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b want 1", idle); end
    endtask

    task automatic test_single();
        int we_cnt;
        we_cnt = 0;
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        n_checks++; if (pending_mask[5] !== 1'b1 || we3 !== 1'b0) begin n_fail++; $display("FAIL single_buffered pm5=%b we3=%b want 1/0", pending_mask[5], we3); end
        tick();
        n_checks++; if ({we3, wa3, wd3} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_fail++; $display("FAIL single_port got %b/%0d/%h want 1/5/deadbeef", we3, wa3, wd3); end
        n_checks++; if (pending_mask !== 32'h20) begin n_fail++; $display("FAIL single_pending got %h want 20", pending_mask); end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (we3) we_cnt++;
        end
        n_checks++; if (we_cnt !== 0) begin n_fail++; $display("FAIL single_extra_writes got %0d want 0", we_cnt); end
        n_checks++; if (idle !== 1'b1 || pending_mask !== 32'd0) begin n_fail++; $display("FAIL single_idle got %b/%h want 1/0", idle, pending_mask); end
    endtask

    task automatic test_contention();
        logic [31:0] q0[$];
        logic [31:0] q1[$];
        logic [31:0] exp;
        int nw;
        nw = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                set_req(0, 1'b1, 5'd3, 32'h100 + c);
                set_req(1, 1'b1, 5'd7, 32'h200 + c);
            end else begin
                req_valid = '0;
            end
            n_checks++; if (req_ready !== m_ready()) begin n_fail++; $display("FAIL contention_ready c=%0d got %b want %b", c, req_ready, m_ready()); end
            if (req_valid[0] && req_ready[0]) q0.push_back(req_data[31:0]);
            if (req_valid[1] && req_ready[1]) q1.push_back(req_data[63:32]);
            tick();
            n_checks++; if ({we3, wa3, wd3, pending_mask, idle} !== {m_we, m_wa, m_wd, exp_pm(), exp_idle()})
                begin n_fail++; $display("FAIL contention_port c=%0d got %b/%0d/%h want %b/%0d/%h", c, we3, wa3, wd3, m_we, m_wa, m_wd); end
            if (we3 === 1'b1) begin
                nw++;
                if (wa3 == 5'd3 && q0.size() > 0) exp = q0.pop_front();
                else if (wa3 == 5'd7 && q1.size() > 0) exp = q1.pop_front();
                else exp = 32'hXXXXXXXX;
                n_checks++; if (wd3 !== exp) begin n_fail++; $display("FAIL contention_order got %h want %h", wd3, exp); end
            end
        end
        n_checks++; if (q0.size() != 0 || q1.size() != 0 || nw < 8) begin n_fail++; $display("FAIL contention_lost left %0d/%0d writes %0d", q0.size(), q1.size(), nw); end
    endtask

    task automatic test_zero_discard();
        set_req(1, 1'b1, 5'd0, 32'h1234);
        n_checks++; if (req_ready[1] !== 1'b1) begin n_fail++; $display("FAIL zero_ready got %b want 1", req_ready[1]); end
        tick();
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            n_checks++; if ({we3, pending_mask, idle} !== {1'b0, 32'd0, 1'b1}) begin n_fail++; $display("FAIL zero_discard c=%0d got %b/%h/%b want 0/0/1", c, we3, pending_mask, idle); end
            tick();
        end
    endtask

    task automatic test_collision();
        if (m_ptr != 0) begin
            set_req(1, 1'b1, 5'd1, 32'h55);
            tick();
            req_valid = '0;
            tick(); tick();
        end
        set_req(0, 1'b1, 5'd9, 32'hA);
        set_req(1, 1'b1, 5'd9, 32'hB);
        tick();
        req_valid = '0;
        tick();
        n_checks++; if ({we3, wa3, wd3} !== {1'b1, 5'd9, 32'hA}) begin n_fail++; $display("FAIL collision_first got %b/%0d/%h want 1/9/a", we3, wa3, wd3); end
        tick();
        n_checks++; if ({we3, wa3, wd3} !== {1'b1, 5'd9, 32'hB}) begin n_fail++; $display("FAIL collision_second got %b/%0d/%h want 1/9/b", we3, wa3, wd3); end
        tick(); tick();
        n_checks++; if (rf[9] !== 32'hB) begin n_fail++; $display("FAIL collision_final got %h want b", rf[9]); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        set_req(0, 1'b1, 5'd4, 32'hC0C0);
        set_req(1, 1'b1, 5'd6, 32'hD0D0);
        tick();
        req_valid = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if ({we3, pending_mask, req_ready} !== {1'b0, 32'd0, 2'b11}) begin n_fail++; $display("FAIL resetmid_state got %b/%h/%b want 0/0/11", we3, pending_mask, req_ready); end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (we3 === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL resetmid_leak got %0d writes want 0", seen); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 2; i++) begin
                set_req(i, 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 12)), $urandom);
            end
            n_checks++; if (req_ready !== m_ready()) begin n_fail++; $display("FAIL random_ready c=%0d got %b want %b", c, req_ready, m_ready()); end
            tick();
            n_checks++; if ({we3, wa3, wd3, pending_mask, idle} !== {m_we, m_wa, m_wd, exp_pm(), exp_idle()})
                begin n_fail++; $display("FAIL random_port c=%0d got %b/%0d/%h/%h/%b want %b/%0d/%h/%h/%b", c, we3, wa3, wd3, pending_mask, idle, m_we, m_wa, m_wd, exp_pm(), exp_idle()); end
        end
        req_valid = '0;
        tick(); tick(); tick();
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL random_drain got idle %b want 1", idle); end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = '0;
        test_reset();
        test_single();
        test_contention();
        test_zero_discard();
        test_collision();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
